// File: rtl/instruction_cache_pkg.sv
// Shared constants, FSM encoding and address helpers for the instruction cache.
package instruction_cache_pkg;

   localparam int WORD_SIZE       = 32;
   localparam int CACHE_LINE_SIZE = 128;
   localparam int ICACHE_LINES    = 4;

   // Miss-handling FSM encoding
   typedef enum logic [1:0] {
      ICACHE_IDLE = 2'd0,
      ICACHE_MISS = 2'd1,
      ICACHE_FILL = 2'd2
   } icache_state_t;

   // Line-aligned address of the line holding a byte address
   function automatic logic [WORD_SIZE-1:0] line_base(input logic [WORD_SIZE-1:0] addr);
      return {addr[WORD_SIZE-1:4], 4'b0000};
   endfunction

endpackage

// File: rtl/instruction_cache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Combinational read port, one synchronous write port, synchronous clear-all.
module instruction_cache_array
   import instruction_cache_pkg::*;
#(
   parameter int NUM_LINES = ICACHE_LINES,
   parameter int TAG_W     = 26
) (
   input  logic                       clk,
   input  logic                       srst,
   input  logic                       clear,
   input  logic [$clog2(NUM_LINES)-1:0] rd_index,
   output logic                       rd_valid,
   output logic [TAG_W-1:0]           rd_tag,
   output logic [CACHE_LINE_SIZE-1:0] rd_line,
   input  logic                       wr_en,
   input  logic [$clog2(NUM_LINES)-1:0] wr_index,
   input  logic [TAG_W-1:0]           wr_tag,
   input  logic [CACHE_LINE_SIZE-1:0] wr_line
);

   localparam int IDX_W = $clog2(NUM_LINES);

   logic [NUM_LINES-1:0]       valid_reg;
   logic [NUM_LINES-1:0]       wr_sel;
   logic [TAG_W-1:0]           tag_mem  [NUM_LINES];
   logic [CACHE_LINE_SIZE-1:0] data_mem [NUM_LINES];

   // One-hot decode of the write index
   genvar gi;
   generate
      for (gi = 0; gi < NUM_LINES; gi++) begin : g_wr_sel
         assign wr_sel[gi] = wr_en && (wr_index == IDX_W'(gi));
      end
   endgenerate

   // Valid bits: clear-all has priority over a same-edge fill
   always_ff @(posedge clk) begin
      if (srst || clear) begin
         valid_reg <= '0;
      end else begin
         valid_reg <= valid_reg | wr_sel;
      end
   end

   // Tag and data storage; contents are only meaningful behind a valid bit
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_line;
      end
   end

   assign rd_valid = valid_reg[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, blocking line
// fill from instruction memory on a miss, then the lookup is replayed.
module instruction_cache
   import instruction_cache_pkg::*;
#(
   parameter int NUM_LINES  = ICACHE_LINES,
   parameter int LINE_WORDS = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WORD_SIZE-1:0]       PC,
   input  logic                       Req,
   input  logic                       Invalidate,
   output logic [WORD_SIZE-1:0]       Instr,
   output logic                       Valid,
   output logic                       Stall,
   output logic                       MemRead,
   output logic [WORD_SIZE-1:0]       MemAddr,
   input  logic                       MemReady,
   input  logic [CACHE_LINE_SIZE-1:0] MemLine
);

   localparam int OFF_W   = $clog2(LINE_WORDS);
   localparam int IDX_W   = $clog2(NUM_LINES);
   localparam int IDX_LSB = 2 + OFF_W;
   localparam int TAG_W   = WORD_SIZE - IDX_LSB - IDX_W;

   icache_state_t        state_reg, state_next;
   logic                 mem_read_reg, mem_read_next;
   logic [WORD_SIZE-1:0] mem_addr_reg, mem_addr_next;

   logic [OFF_W-1:0]           lookup_offset;
   logic [IDX_W-1:0]           lookup_index;
   logic [TAG_W-1:0]           lookup_tag;
   logic                       rd_valid;
   logic [TAG_W-1:0]           rd_tag;
   logic [CACHE_LINE_SIZE-1:0] rd_line;
   logic [WORD_SIZE-1:0]       line_words [LINE_WORDS];
   logic                       hit;
   logic                       stall_int;
   logic                       fill_en;
   logic                       unused_bits;

   assign lookup_offset = PC[2 +: OFF_W];
   assign lookup_index  = PC[IDX_LSB +: IDX_W];
   assign lookup_tag    = PC[WORD_SIZE-1 -: TAG_W];

   // Fill write happens on the edge where memory reports the line ready
   assign fill_en = (state_reg == ICACHE_MISS) && MemReady && !rst;

   instruction_cache_array #(
      .NUM_LINES (NUM_LINES),
      .TAG_W     (TAG_W)
   ) u_array (
      .clk      (clk),
      .srst     (rst),
      .clear    (Invalidate),
      .rd_index (lookup_index),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_line  (rd_line),
      .wr_en    (fill_en),
      .wr_index (mem_addr_reg[IDX_LSB +: IDX_W]),
      .wr_tag   (mem_addr_reg[WORD_SIZE-1 -: TAG_W]),
      .wr_line  (MemLine)
   );

   // Split the line into words for the offset mux
   genvar gi;
   generate
      for (gi = 0; gi < LINE_WORDS; gi++) begin : g_words
         assign line_words[gi] = rd_line[gi*WORD_SIZE +: WORD_SIZE];
      end
   endgenerate

   // Hits are only served from IDLE so a fill never races a lookup
   assign hit   = (state_reg == ICACHE_IDLE) && Req && rd_valid &&
                  (rd_tag == lookup_tag) && !rst;
   assign Instr = line_words[lookup_offset];
   assign Valid = hit;
   assign Stall = stall_int;

   // Byte-offset bits and the zero low bits of the miss address carry no information
   assign unused_bits = ^{PC[1:0], mem_addr_reg[IDX_LSB-1:0]};

   // Next-state, memory request and stall decode
   always_comb begin
      state_next    = state_reg;
      mem_read_next = mem_read_reg;
      mem_addr_next = mem_addr_reg;
      stall_int     = 1'b0;
      case (state_reg)
         ICACHE_IDLE: begin
            if (Req && !hit) begin
               stall_int     = 1'b1;
               state_next    = ICACHE_MISS;
               mem_read_next = 1'b1;
               mem_addr_next = line_base(PC);
            end
         end
         ICACHE_MISS: begin
            stall_int = 1'b1;
            if (MemReady) begin
               state_next    = ICACHE_FILL;
               mem_read_next = 1'b0;
            end
         end
         ICACHE_FILL: begin
            // Read stays low here, giving memory a full idle cycle between requests
            stall_int  = 1'b1;
            state_next = ICACHE_IDLE;
         end
         default: begin
            state_next    = ICACHE_IDLE;
            mem_read_next = 1'b0;
         end
      endcase
      if (rst) begin
         stall_int = 1'b0;
      end
   end

   // FSM and registered memory interface
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ICACHE_IDLE;
         mem_read_reg <= 1'b0;
         mem_addr_reg <= '0;
      end else begin
         state_reg    <= state_next;
         mem_read_reg <= mem_read_next;
         mem_addr_reg <= mem_addr_next;
      end
   end

   assign MemRead = mem_read_reg;
   assign MemAddr = mem_addr_reg;

endmodule
